// File: rtl/ds_beamformer_array.sv
// ds_beamformer_array
//   Multi-beam transmit beamformer with a ternary delta-sigma modulator per
//   antenna element. Each element forms x_e = sum_b (I_b*cos_be - Q_b*sin_be)
//   from the captured beam samples and the active weight bank, then noise-shapes
//   x_e (1st or 2nd order, error-feedback form) into a ternary pwm code on every
//   clock, so the modulator oversamples relative to in_valid.
//   Weights are written into a shadow bank and copied to the active bank as one
//   atomic operation on a sample boundary.
//
// Ports
//   clock          oversampling clock
//   reset          synchronous, active-high; clears all state
//   in_valid       sample strobe; vin_i/vin_q captured on this edge
//   vin_i, vin_q   beam b sample at [b*IN_W +: IN_W], signed
//   wr_en          write wr_data into shadow[wr_sel][wr_beam][wr_elem]
//   wr_sel         0 = cos bank, 1 = sin bank
//   wr_beam        beam index (out-of-range writes are dropped)
//   wr_elem        element index (out-of-range writes are dropped)
//   wr_data        signed weight
//   commit         request shadow -> active copy at the next sample boundary
//   out_en         0 mutes pwm and clears modulator state
//   pwm            element e at [2e +: 2]: 01 = +1, 11 = -1, 00 = 0
//   commit_pending commit requested, copy not yet performed
//   sat            per element, high for one cycle when the modulator clipped

module ds_beamformer_array #(
  parameter int N_BEAMS = 2,
  parameter int N_ELEM  = 8,
  parameter int IN_W    = 8,
  parameter int W_W     = 5,
  parameter int ORDER   = 2,
  parameter int ACC_W   = IN_W + W_W + 1 + $clog2(N_BEAMS)
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           in_valid,
  input  logic [N_BEAMS*IN_W-1:0]                        vin_i,
  input  logic [N_BEAMS*IN_W-1:0]                        vin_q,
  input  logic                                           wr_en,
  input  logic                                           wr_sel,
  input  logic [((N_BEAMS > 1) ? $clog2(N_BEAMS) : 1)-1:0] wr_beam,
  input  logic [((N_ELEM > 1) ? $clog2(N_ELEM) : 1)-1:0]   wr_elem,
  input  logic [W_W-1:0]                                 wr_data,
  input  logic                                           commit,
  input  logic                                           out_en,
  output logic [2*N_ELEM-1:0]                            pwm,
  output logic                                           commit_pending,
  output logic [N_ELEM-1:0]                              sat
);

  // Modulator datapath width: headroom for x + 2*e1 - e2 before clipping.
  localparam int MW = ACC_W + 3;

  // FS = 2^(ACC_W-1); clip limit is +/-(2*FS-1) = +/-(2^ACC_W - 1).
  localparam logic signed [MW-1:0] FS    = {{(MW-ACC_W){1'b0}}, 1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [MW-1:0] HALF  = FS >>> 1;
  localparam logic signed [MW-1:0] NHALF = -HALF;
  localparam logic signed [MW-1:0] SMAX  = {{(MW-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic signed [MW-1:0] SMIN  = -SMAX;

  // Captured beam samples
  logic signed [IN_W-1:0]  samp_i     [N_BEAMS];
  logic signed [IN_W-1:0]  samp_q     [N_BEAMS];

  // Weight banks
  logic signed [W_W-1:0]   shadow_cos [N_BEAMS][N_ELEM];
  logic signed [W_W-1:0]   shadow_sin [N_BEAMS][N_ELEM];
  logic signed [W_W-1:0]   act_cos    [N_BEAMS][N_ELEM];
  logic signed [W_W-1:0]   act_sin    [N_BEAMS][N_ELEM];

  // Mix stage
  logic signed [ACC_W-1:0] mix        [N_ELEM];
  logic signed [ACC_W-1:0] mix_next   [N_ELEM];
  logic signed [ACC_W-1:0] acc;

  // Modulator state and next-state
  logic signed [MW-1:0]    e1         [N_ELEM];
  logic signed [MW-1:0]    e2         [N_ELEM];
  logic signed [MW-1:0]    mod_e1     [N_ELEM];
  logic [2*N_ELEM-1:0]     mod_code;
  logic [N_ELEM-1:0]       mod_sat;
  logic signed [MW-1:0]    u;
  logic signed [MW-1:0]    err;
  logic [1:0]              code;
  logic                    clip;

  logic                    wr_in_range;
  logic                    do_copy;

  assign wr_in_range = (32'(wr_beam) < N_BEAMS) && (32'(wr_elem) < N_ELEM);

  // A pending request, or one arriving this very edge, is served by in_valid.
  assign do_copy = in_valid && (commit_pending || commit);

  // Mix: operands are sign-extended to ACC_W first so products and the beam
  // sum are formed at full precision.
  always_comb begin
    acc = '0;
    for (int unsigned e = 0; e < N_ELEM; e++) begin
      acc = '0;
      for (int unsigned b = 0; b < N_BEAMS; b++) begin
        acc = acc
            + ACC_W'(samp_i[b]) * ACC_W'(act_cos[b][e])
            - ACC_W'(samp_q[b]) * ACC_W'(act_sin[b][e]);
      end
      mix_next[e] = acc;
    end
  end

  // Error-feedback modulator: shape, clip, ternary quantise, new error.
  always_comb begin
    u        = '0;
    err      = '0;
    code     = 2'b00;
    clip     = 1'b0;
    mod_code = '0;
    mod_sat  = '0;
    for (int unsigned e = 0; e < N_ELEM; e++) begin
      if (ORDER == 1) begin
        u = MW'(mix[e]) + e1[e];
      end else begin
        u = MW'(mix[e]) + e1[e] + e1[e] - e2[e];
      end

      clip = 1'b0;
      if (u > SMAX) begin
        u    = SMAX;
        clip = 1'b1;
      end else if (u < SMIN) begin
        u    = SMIN;
        clip = 1'b1;
      end

      if (u >= HALF) begin
        code = 2'b01;
        err  = u - FS;
      end else if (u < NHALF) begin
        code = 2'b11;
        err  = u + FS;
      end else begin
        code = 2'b00;
        err  = u;
      end

      mod_e1[e]          = err;
      mod_code[2*e +: 2] = code;
      mod_sat[e]         = clip;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_pending <= 1'b0;
      pwm            <= '0;
      sat            <= '0;
      for (int unsigned b = 0; b < N_BEAMS; b++) begin
        samp_i[b] <= '0;
        samp_q[b] <= '0;
        for (int unsigned e = 0; e < N_ELEM; e++) begin
          shadow_cos[b][e] <= '0;
          shadow_sin[b][e] <= '0;
          act_cos[b][e]    <= '0;
          act_sin[b][e]    <= '0;
        end
      end
      for (int unsigned e = 0; e < N_ELEM; e++) begin
        mix[e] <= '0;
        e1[e]  <= '0;
        e2[e]  <= '0;
      end
    end else begin
      if (in_valid) begin
        for (int unsigned b = 0; b < N_BEAMS; b++) begin
          samp_i[b] <= vin_i[b*IN_W +: IN_W];
          samp_q[b] <= vin_q[b*IN_W +: IN_W];
        end
      end

      // The copy below reads the shadow bank before this edge's write lands,
      // so a simultaneous write reaches the shadow bank only.
      if (wr_en && wr_in_range) begin
        if (wr_sel) begin
          shadow_sin[wr_beam][wr_elem] <= wr_data;
        end else begin
          shadow_cos[wr_beam][wr_elem] <= wr_data;
        end
      end

      if (do_copy) begin
        act_cos        <= shadow_cos;
        act_sin        <= shadow_sin;
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end

      for (int unsigned e = 0; e < N_ELEM; e++) begin
        mix[e] <= mix_next[e];
      end

      if (!out_en) begin
        pwm <= '0;
        sat <= '0;
        for (int unsigned e = 0; e < N_ELEM; e++) begin
          e1[e] <= '0;
          e2[e] <= '0;
        end
      end else begin
        pwm <= mod_code;
        sat <= mod_sat;
        for (int unsigned e = 0; e < N_ELEM; e++) begin
          e2[e] <= e1[e];
          e1[e] <= mod_e1[e];
        end
      end
    end
  end

endmodule
